// File: rtl/car_path_sequencer.sv
// car_path_sequencer: steps a 20x20 car sprite across one row with draw/hold/erase/move passes.
//   clk, reset      : clock, synchronous active-high reset
//   start           : begin a run (sampled only while idle)
//   frame_tick      : one pulse per video frame, paces the hold between moves
//   draw_done       : sprite drawer completion flag, used on its rising edge
//   car_x, car_y    : sprite top-left coordinate for the drawer
//   erase, plot     : background-select and VGA write enable for the current pass
//   busy, arrived   : run in progress, one-cycle pulse after the final draw at X_END
module car_path_sequencer #(
    parameter logic [7:0] X_START         = 8'd0,
    parameter logic [7:0] X_END           = 8'd140,
    parameter logic [6:0] Y_ROW           = 7'd50,
    parameter logic [7:0] STEP            = 8'd4,
    parameter logic [3:0] FRAMES_PER_STEP = 4'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       draw_done,
    output logic [7:0] car_x,
    output logic [6:0] car_y,
    output logic       erase,
    output logic       plot,
    output logic       busy,
    output logic       arrived
);
    typedef enum logic [2:0] {IDLE, DRAW, WAIT_DRAW, HOLD, ERASE, WAIT_ERASE, MOVE} state_t;
    state_t     state;
    logic       draw_done_q;
    logic       done_edge;
    logic [3:0] frame_cnt;
    logic [8:0] next_x;
    assign done_edge = draw_done & ~draw_done_q;
    // nine bits so the step can never wrap past 255 before clamping
    assign next_x = {1'b0, car_x} + {1'b0, STEP};
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            car_x       <= X_START;
            car_y       <= Y_ROW;
            erase       <= 1'b0;
            plot        <= 1'b0;
            busy        <= 1'b0;
            arrived     <= 1'b0;
            frame_cnt   <= 4'd0;
            draw_done_q <= 1'b0;
        end else begin
            draw_done_q <= draw_done;
            arrived     <= 1'b0;
            // outputs are loaded together with the state they belong to
            case (state)
                IDLE: if (start) begin
                    car_x <= X_START;
                    car_y <= Y_ROW;
                    state <= DRAW;
                    plot  <= 1'b1;
                    erase <= 1'b0;
                    busy  <= 1'b1;
                end
                DRAW: state <= WAIT_DRAW;
                WAIT_DRAW: if (done_edge) begin
                    plot      <= 1'b0;
                    frame_cnt <= 4'd0;
                    if (car_x == X_END) begin
                        arrived <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: if (frame_tick) begin
                    if (frame_cnt + 4'd1 == FRAMES_PER_STEP) begin
                        frame_cnt <= 4'd0;
                        state     <= ERASE;
                        plot      <= 1'b1;
                        erase     <= 1'b1;
                    end else begin
                        frame_cnt <= frame_cnt + 4'd1;
                    end
                end
                ERASE: state <= WAIT_ERASE;
                WAIT_ERASE: if (done_edge) begin
                    state <= MOVE;
                    plot  <= 1'b0;
                    erase <= 1'b0;
                end
                MOVE: begin
                    car_x <= (next_x > {1'b0, X_END}) ? X_END : next_x[7:0];
                    state <= DRAW;
                    plot  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_car_path_sequencer.sv
// tb_car_path_sequencer: table vectors plus randomized full runs against a path-level model.
module tb_car_path_sequencer;
    localparam int XS[3] = '{0, 0, 60};
    localparam int XE[3] = '{140, 10, 60};
    localparam int ST[3] = '{4, 4, 4};
    localparam int FP[3] = '{2, 1, 3};
    localparam int YR[3] = '{50, 50, 33};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start [3];
    logic       draw_done [3];
    logic [7:0] car_x [3];
    logic [6:0] car_y [3];
    logic       erase [3];
    logic       plot [3];
    logic       busy [3];
    logic       arrived [3];
    int         passed = 0;
    int         total = 0;

    always #5 clk = ~clk;

    car_path_sequencer u0 (
        .clk(clk), .reset(reset), .start(start[0]), .frame_tick(frame_tick), .draw_done(draw_done[0]),
        .car_x(car_x[0]), .car_y(car_y[0]), .erase(erase[0]), .plot(plot[0]), .busy(busy[0]), .arrived(arrived[0])
    );
    car_path_sequencer #(.X_START(8'd0), .X_END(8'd10), .Y_ROW(7'd50), .STEP(8'd4), .FRAMES_PER_STEP(4'd1)) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .frame_tick(frame_tick), .draw_done(draw_done[1]),
        .car_x(car_x[1]), .car_y(car_y[1]), .erase(erase[1]), .plot(plot[1]), .busy(busy[1]), .arrived(arrived[1])
    );
    car_path_sequencer #(.X_START(8'd60), .X_END(8'd60), .Y_ROW(7'd33), .STEP(8'd4), .FRAMES_PER_STEP(4'd3)) u2 (
        .clk(clk), .reset(reset), .start(start[2]), .frame_tick(frame_tick), .draw_done(draw_done[2]),
        .car_x(car_x[2]), .car_y(car_y[2]), .erase(erase[2]), .plot(plot[2]), .busy(busy[2]), .arrived(arrived[2])
    );

    typedef struct {
        logic rst, st, dd, ft;
        logic ep, ee, eb, ea;
        int   ex;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drives one complete run on instance k with a drawer model and checks the visited
    // columns, pass kinds, hold length and the single arrival against the path model.
    task automatic run_path(input int k, input int dly, input int tick_per, input bit spam, input int abort_x);
        int xs[$];
        int x, draws, erases, arrs, dcount, ticks, pass_x, age, viol, idle_busy;
        bit prev_plot, prev_erase, in_hold, done, tick;
        x = XS[k];
        while (1) begin
            xs.push_back(x);
            if (x == XE[k]) break;
            x = (x + ST[k] > XE[k]) ? XE[k] : x + ST[k];
        end
        draws = 0; erases = 0; arrs = 0; dcount = -1; ticks = 0; pass_x = -1; age = 0; viol = 0;
        prev_plot = 0; prev_erase = 0; in_hold = 0; done = 0;
        start[k] = 1'b1;
        for (int cyc = 0; cyc < 80000 && !done; cyc++) begin
            @(negedge clk);
            draw_done[k] = 1'b0;
            if (plot[k] && !prev_plot) begin
                pass_x = car_x[k];
                age = 0;
                chk("pass car_y", car_y[k], YR[k]);
                if (!erase[k]) begin
                    chk("draw car_x", car_x[k], draws < xs.size() ? xs[draws] : -1);
                    draws++;
                end else begin
                    chk("erase car_x", car_x[k], draws > 0 ? xs[draws-1] : -1);
                    chk("hold frame ticks", ticks, FP[k]);
                    erases++;
                end
                in_hold = 0;
                dcount = dly > 0 ? dly : int'($urandom_range(2, 20));
            end else if (plot[k] && car_x[k] != pass_x) begin
                viol++;
            end
            if (!plot[k] && prev_plot && !prev_erase && busy[k]) begin
                in_hold = 1;
                ticks = 0;
            end
            if (arrived[k]) begin
                arrs++;
                chk("arrived car_x", car_x[k], XE[k]);
                chk("arrived busy", busy[k], 0);
                done = 1;
            end
            if (abort_x >= 0 && plot[k] && erase[k] && pass_x == abort_x && age == 2) begin
                reset = 1'b1; start[k] = 1'b0; frame_tick = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                chk("abort plot", plot[k], 0);
                chk("abort erase", erase[k], 0);
                chk("abort busy", busy[k], 0);
                chk("abort car_x", car_x[k], XS[k]);
                chk("abort car_y", car_y[k], YR[k]);
                return;
            end
            if (dcount > 0) begin
                dcount--;
                if (dcount == 0) draw_done[k] = 1'b1;
            end
            tick = tick_per > 0 ? (cyc % tick_per == 0) : ($urandom_range(0, 3) == 0);
            frame_tick = tick;
            if (in_hold && tick) ticks++;
            start[k] = (!done && spam) ? ($urandom_range(0, 2) == 0) : 1'b0;
            prev_plot = plot[k];
            prev_erase = erase[k];
            age++;
        end
        start[k] = 1'b0; draw_done[k] = 1'b0;
        chk("arrived within budget", done, 1);
        chk("draw pass count", draws, xs.size());
        chk("erase pass count", erases, xs.size() - 1);
        chk("coords stable in pass", viol, 0);
        idle_busy = 0;
        repeat (20) begin
            frame_tick = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            arrs += arrived[k];
            idle_busy += busy[k] | plot[k];
        end
        frame_tick = 1'b0;
        chk("arrived pulse count", arrs, 1);
        chk("idle after arrival", idle_busy, 0);
    endtask

    initial begin
        vec_t tv[13];
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            draw_done[i] = 1'b0;
        end
        tv[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 60};
        tv[1]  = '{0, 1, 0, 0, 1, 0, 1, 0, 60};
        tv[2]  = '{0, 0, 0, 0, 1, 0, 1, 0, 60};
        tv[3]  = '{0, 0, 1, 0, 0, 0, 0, 1, 60};
        tv[4]  = '{0, 0, 1, 0, 0, 0, 0, 0, 60};
        tv[5]  = '{0, 1, 1, 0, 1, 0, 1, 0, 60};
        tv[6]  = '{0, 0, 1, 0, 1, 0, 1, 0, 60};
        tv[7]  = '{0, 0, 1, 0, 1, 0, 1, 0, 60};
        tv[8]  = '{0, 0, 0, 0, 1, 0, 1, 0, 60};
        tv[9]  = '{0, 0, 1, 0, 0, 0, 0, 1, 60};
        tv[10] = '{0, 1, 0, 1, 1, 0, 1, 0, 60};
        tv[11] = '{1, 1, 0, 0, 0, 0, 0, 0, 60};
        tv[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 60};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset car_x u%0d", i), car_x[i], XS[i]);
            chk($sformatf("reset car_y u%0d", i), car_y[i], YR[i]);
            chk($sformatf("reset busy u%0d", i), busy[i], 0);
            chk($sformatf("reset plot u%0d", i), plot[i], 0);
        end
        for (int i = 0; i < 13; i++) begin
            reset = tv[i].rst; start[2] = tv[i].st; draw_done[2] = tv[i].dd; frame_tick = tv[i].ft;
            @(negedge clk);
            chk($sformatf("vec%0d plot", i), plot[2], tv[i].ep);
            chk($sformatf("vec%0d erase", i), erase[2], tv[i].ee);
            chk($sformatf("vec%0d busy", i), busy[2], tv[i].eb);
            chk($sformatf("vec%0d arrived", i), arrived[2], tv[i].ea);
            chk($sformatf("vec%0d car_x", i), car_x[2], tv[i].ex);
        end
        reset = 1'b0; start[2] = 1'b0; draw_done[2] = 1'b0; frame_tick = 1'b0;
        @(negedge clk);
        run_path(0, 400, 50, 1'b0, -1);
        for (int r = 0; r < 3; r++) run_path(1, 0, 0, 1'b1, -1);
        run_path(0, 0, 0, 1'b1, -1);
        run_path(0, 5, 0, 1'b0, 24);
        run_path(0, 0, 0, 1'b0, -1);
        for (int r = 0; r < 2; r++) run_path(2, 0, 0, 1'b1, -1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/car_path_sequencer.md
CAR_PATH_SEQUENCER -- requirements
Module: car_path_sequencer

Interface
REQ-001 Parameter X_START, 8'd0: car origin column.
REQ-002 Parameter X_END, 8'd140: final column; must satisfy X_START <= X_END <= 140, so the 20x20 sprite stays inside 160 columns.
REQ-003 Parameter Y_ROW, 7'd50: fixed car row.
REQ-004 Parameter STEP, 8'd4: columns advanced per move; range 1..20.
REQ-005 Parameter FRAMES_PER_STEP, 4'd2: frame ticks waited between moves; range 1..15.
REQ-006 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port start, input, 1: one-cycle request to begin a run; sampled only in IDLE.
REQ-009 Port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-010 Port draw_done, input, 1: completion flag from the 20x20 sprite drawer.
REQ-011 Port car_x, output, 8: sprite top-left column; drives drawer COUNTER_X.
REQ-012 Port car_y, output, 7: sprite top-left row; drives drawer COUNTER_Y.
REQ-013 Port erase, output, 1: 1 = the pixel mux selects background colour; 0 = selects sprite colour.
REQ-014 Port plot, output, 1: VGA write enable for the current sprite pass.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port arrived, output, 1: one-cycle pulse when the car has been drawn at X_END.

Function
REQ-017 FSM states: IDLE, DRAW, WAIT_DRAW, HOLD, ERASE, WAIT_ERASE, MOVE.
REQ-018 IDLE: start=1 SHALL load car_x=X_START and car_y=Y_ROW, then go to DRAW. start=0 SHALL keep the FSM in IDLE.
REQ-019 DRAW: one cycle with erase=0 and plot=1; go to WAIT_DRAW.
REQ-020 WAIT_DRAW: plot=1 and erase=0 while waiting for a draw_done rising edge.
REQ-021 draw_done SHALL be registered once, and the edge SHALL be detected as (draw_done & ~draw_done_q).
REQ-022 A draw_done level that is already high on entry SHALL NOT complete a pass.
REQ-023 WAIT_DRAW exit on the edge: if car_x==X_END, pulse arrived and go to IDLE; otherwise go to HOLD.
REQ-024 HOLD: plot=0 while counting frame_tick pulses. When the count reaches FRAMES_PER_STEP, clear the counter and go to ERASE.
REQ-025 ERASE: one cycle with erase=1 and plot=1; go to WAIT_ERASE.
REQ-026 WAIT_ERASE: plot=1 and erase=1 until a draw_done rising edge; then go to MOVE.
REQ-027 MOVE: car_x <= min(car_x+STEP, X_END); go to DRAW.
REQ-028 The MOVE sum SHALL be computed 9 bits wide so that it cannot wrap.
REQ-029 car_y SHALL be constant for the whole run.
REQ-030 car_x and car_y SHALL change only in IDLE (on start) and in MOVE, so the coordinates are stable for an entire sprite pass.
REQ-031 If X_START==X_END: one draw pass, then arrived, then IDLE; no ERASE occurs.
REQ-032 start asserted while busy=1 SHALL be ignored.
REQ-033 frame_tick outside HOLD SHALL be ignored, and the frame counter SHALL be cleared on entry to HOLD.
REQ-034 A draw_done edge and a frame_tick in the same cycle: each is consumed only by the state it belongs to.
REQ-035 All outputs SHALL be registered; state-derived outputs SHALL be valid in the cycle the FSM is in that state.

Reset
REQ-036 reset=1 at any clk edge, including mid-pass, SHALL force state=IDLE, car_x=X_START, car_y=Y_ROW.
REQ-037 reset=1 SHALL also force erase=0, plot=0, busy=0, arrived=0, and clear the frame counter and draw_done_q.
REQ-038 reset SHALL take priority over start.

Verification
REQ-039 Defaults; start pulse; drawer model asserts draw_done 400 cycles after each DRAW/ERASE; frame_tick every 50 cycles -> car_x sequence 0,4,8,...,140. Expect 36 draw passes, 35 erase passes, exactly one arrived pulse, then busy=0.
REQ-040 X_START=0, X_END=10, STEP=4 -> car_x sequence 0,4,8,10 (clamped), then arrived.
REQ-041 draw_done held high before DRAW and never toggled -> FSM stays in WAIT_DRAW with plot=1 and no arrived; after one 0->1 transition it proceeds.
REQ-042 reset asserted during WAIT_ERASE at car_x=24 -> next cycle state IDLE, car_x=0, plot=0, erase=0, busy=0.
REQ-043 start pulsed repeatedly during a run -> sequence unchanged; X_START==X_END -> single draw, arrived, no erase pass.
